serial_mul_div: RTL and testbench

SERIAL_MUL_DIV -- requirements
Module: serial_mul_div

---
 rtl/serial_mul_div_pkg.sv | 29 ++
 rtl/serial_add_bit.sv | 29 ++
 rtl/serial_mul_div.sv | 190 +++++++++++++++++++
 tb/tb_serial_mul_div.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mul_div_pkg.sv
// Shared types and sizing helpers for the bit-serial sign-magnitude multiplier/divider.
package serial_mul_div_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int unsigned mag_bits(input int unsigned word_bits);
        return word_bits - 1;
    endfunction

    function automatic int unsigned acc_bits(input int unsigned word_bits);
        return 2 * (word_bits - 1);
    endfunction

    // Width of a counter that must hold 0..n-1.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_add_bit.sv
// One-bit serial adder/subtractor with a registered carry/borrow; clr forces a zero carry-in.
module serial_add_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic sub,
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry_nxt
);

    logic carry_q;
    logic cin;

    always_comb begin
        cin       = clr ? 1'b0 : carry_q;
        sum       = x ^ y ^ cin;
        carry_nxt = sub ? ((~x & y) | (~(x ^ y) & cin))
                        : ((x & y) | (cin & (x ^ y)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  carry_q <= 1'b0;
        else if (en) carry_q <= carry_nxt;
    end

endmodule

// File: rtl/serial_mul_div.sv
// Bit-serial sign-magnitude multiply / restoring divide, one ACC_BITS-cycle pass per iteration.
// Optional round-half-up of the product high word: define SERIAL_MUL_DIV_ROUND_EN.
module serial_mul_div
    import serial_mul_div_pkg::*;
#(
    parameter int unsigned WORD_BITS = 29
) (
    input  logic                 CLOCK,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 op,
    input  logic [WORD_BITS-1:0] a,
    input  logic [WORD_BITS-1:0] b_hi,
    input  logic [WORD_BITS-1:0] b_lo,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic [WORD_BITS-1:0] p_hi,
    output logic [WORD_BITS-1:0] p_lo
);

    localparam int unsigned MAG  = mag_bits(WORD_BITS);
    localparam int unsigned ACC  = acc_bits(WORD_BITS);
    localparam int unsigned BT_W = cnt_bits(ACC);
    localparam int unsigned IT_W = cnt_bits(MAG);

    state_e          state, state_nxt;
    op_e             op_q;
    logic [BT_W-1:0] bt;
    logic [IT_W-1:0] it;
    logic [ACC-1:0]  id_line, pn, id_rot;
    logic [ACC-2:0]  sum_line;
    logic [MAG-1:0]  mq;
    logic            sign_a, sign_b, ovf_pend;

    logic wrap, last_it, div_ovf, add_y, sum_bit, carry_nxt, commit;
    logic busy_nxt, done_nxt, op_cap, load_en, iter_en, res_upd;
    logic [WORD_BITS-1:0] res_hi, res_lo;

    assign wrap    = (bt == BT_W'(ACC - 1));
    assign last_it = (it == IT_W'(MAG - 1));
    assign div_ovf = (op_q == OP_DIV) && (b_hi[WORD_BITS-1:1] >= a[WORD_BITS-1:1]);
    assign id_rot  = {id_line[0], id_line[ACC-1:1]};

    // MUL adds ID only when the current multiplier bit is set; DIV always trial-subtracts.
    assign add_y  = id_line[0] & ((op_q == OP_DIV) | mq[0]);
    assign commit = (op_q == OP_MUL) | ~carry_nxt;

    serial_add_bit u_add (
        .clk       (CLOCK),
        .rst_n     (rst_n),
        .clr       (bt == '0),
        .en        (iter_en),
        .sub       (op_q == OP_DIV),
        .x         (pn[0]),
        .y         (add_y),
        .sum       (sum_bit),
        .carry_nxt (carry_nxt)
    );

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !abort) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (abort)        state_nxt = ST_IDLE;
                else if (div_ovf) state_nxt = ST_DONE;
                else              state_nxt = ST_ITER;
            end
            ST_ITER: begin
                if (abort)                state_nxt = ST_IDLE;
                else if (wrap && last_it) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_ITER);
        done_nxt = (state == ST_DONE);
        res_upd  = (state == ST_DONE);
        op_cap   = (state == ST_IDLE) && start && !abort;
        load_en  = (state == ST_LOAD) && !abort;
        iter_en  = (state == ST_ITER) && !abort;
    end

    // Operand lines rotate LSB first; a full pass returns them to their original alignment.
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            bt       <= '0;
            it       <= '0;
            id_line  <= '0;
            pn       <= '0;
            sum_line <= '0;
            mq       <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            ovf_pend <= 1'b0;
        end else begin
            if (op_cap) op_q <= op_e'(op);
            if (load_en) begin
                bt       <= '0;
                it       <= '0;
                sum_line <= '0;
                sign_a   <= a[0];
                ovf_pend <= div_ovf;
                if (op_q == OP_MUL) begin
                    id_line <= ACC'(a[WORD_BITS-1:1]);
                    mq      <= b_lo[WORD_BITS-1:1];
                    pn      <= '0;
                    sign_b  <= b_lo[0];
                end else begin
                    id_line <= ACC'(a[WORD_BITS-1:1]) << (MAG - 1);
                    mq      <= '0;
                    pn      <= {b_hi[WORD_BITS-1:1], b_lo[WORD_BITS-1:1]};
                    sign_b  <= b_hi[0];
                end
            end else if (iter_en) begin
                sum_line <= {sum_bit, sum_line[ACC-2:1]};
                pn       <= {pn[0], pn[ACC-1:1]};
                id_line  <= id_rot;
                bt       <= bt + BT_W'(1);
                if (wrap) begin
                    bt <= '0;
                    it <= it + IT_W'(1);
                    if (commit) pn <= {sum_bit, sum_line};
                    if (op_q == OP_MUL) begin
                        id_line <= id_rot << 1;
                        mq      <= mq >> 1;
                    end else begin
                        id_line <= id_rot >> 1;
                        mq      <= {mq[MAG-2:0], commit};
                    end
                end
            end
        end
    end

    // Result formatting: sign-magnitude with bit 0 as sign, zero magnitudes never negative.
    always_comb begin
        logic [MAG-1:0] mag_hi;
        logic           s_prod;
        mag_hi = '0;
        s_prod = 1'b0;
        res_hi = '0;
        res_lo = '0;
        if (!ovf_pend) begin
            if (op_q == OP_MUL) begin
`ifdef SERIAL_MUL_DIV_ROUND_EN
                mag_hi = pn[ACC-1:MAG] + MAG'(pn[MAG-1]);
`else
                mag_hi = pn[ACC-1:MAG];
`endif
                s_prod = (sign_a ^ sign_b) & (|pn);
                res_hi = {mag_hi, s_prod};
                res_lo = {pn[MAG-1:0], s_prod};
            end else begin
                res_lo = {mq, (sign_a ^ sign_b) & (|mq)};
                res_hi = {pn[MAG-1:0], sign_b & (|pn[MAG-1:0])};
            end
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            ovf  <= 1'b0;
            p_hi <= '0;
            p_lo <= '0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (res_upd) begin
                ovf  <= ovf_pend;
                p_hi <= res_hi;
                p_lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_serial_mul_div.sv
// Self-checking bench for serial_mul_div (WORD_BITS = 8): directed literals plus random ops vs an arithmetic model.
module tb_serial_mul_div;

    localparam int W   = 8;
    localparam int MAG = 7;
    localparam int ACC = 14;
    localparam int LAT = 2 + MAG * ACC;

    logic         clk = 1'b0;
    logic         rst_n, start, abort, op;
    logic [W-1:0] a, b_hi, b_lo;
    logic         busy, done, ovf;
    logic [W-1:0] p_hi, p_lo;

    serial_mul_div #(.WORD_BITS(W)) dut (
        .CLOCK (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .op    (op),
        .a     (a),
        .b_hi  (b_hi),
        .b_lo  (b_lo),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .p_hi  (p_hi),
        .p_lo  (p_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    bit           pending = 1'b0;
    int           start_edge = 0;
    int           exp_edge = 0;
    int           done_edge = -1;
    logic [W-1:0] exp_hi, exp_lo;
    logic         exp_ovf;
    logic [W-1:0] held_hi = '0;
    logic [W-1:0] held_lo = '0;
    logic         held_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arithmetic reference: magnitudes as integers, signs from the operand sign bits.
    task automatic model(input logic o, input logic [W-1:0] aa, bh, bl,
                         output logic [W-1:0] eh, el, output logic eo, output int lat);
        int ma, mb, mh, prod, hi, lo, dvd, q, r;
        logic s;
        ma = int'(aa[W-1:1]);
        if (!o) begin
            mb   = int'(bl[W-1:1]);
            prod = ma * mb;
            hi   = prod / 128;
            lo   = prod % 128;
`ifdef SERIAL_MUL_DIV_ROUND_EN
            hi   = hi + lo / 64;
`endif
            s    = (aa[0] ^ bl[0]) && (prod != 0);
            eh   = {7'(hi), s};
            el   = {7'(lo), s};
            eo   = 1'b0;
            lat  = LAT;
        end else begin
            mh = int'(bh[W-1:1]);
            if (mh >= ma) begin
                eh  = '0;
                el  = '0;
                eo  = 1'b1;
                lat = 2;
            end else begin
                dvd = mh * 128 + int'(bl[W-1:1]);
                q   = dvd / ma;
                r   = dvd % ma;
                el  = {7'(q), (aa[0] ^ bh[0]) && (q != 0)};
                eh  = {7'(r), bh[0] && (r != 0)};
                eo  = 1'b0;
                lat = LAT;
            end
        end
    endtask

    // Per-cycle compare against the expected done time and the currently held result.
    always @(negedge clk) begin
        logic exp_d, exp_busy;
        exp_d    = pending && (cyc == exp_edge);
        exp_busy = pending && (cyc >= start_edge) && (cyc <= exp_edge - 2);
        check("done", 32'(done), 32'(exp_d));
        check("busy", 32'(busy), 32'(exp_busy));
        if (exp_d) begin
            held_hi   = exp_hi;
            held_lo   = exp_lo;
            held_ovf  = exp_ovf;
            pending   = 1'b0;
            done_edge = cyc;
        end
        check("p_hi", 32'(p_hi), 32'(held_hi));
        check("p_lo", 32'(p_lo), 32'(held_lo));
        check("ovf",  32'(ovf),  32'(held_ovf));
    end

    task automatic run(input logic o, input logic [W-1:0] aa, bh, bl,
                       input int abort_at, input int rst_at, input bit poke, output int lat_obs);
        logic [W-1:0] eh, el;
        logic         eo;
        int           lat, g;
        model(o, aa, bh, bl, eh, el, eo, lat);
        @(negedge clk);
        op = o; a = aa; b_hi = bh; b_lo = bl; start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        done_edge  = -1;
        start_edge = cyc;
        exp_edge   = cyc + lat;
        exp_hi     = eh;
        exp_lo     = el;
        exp_ovf    = eo;
        pending    = 1'b1;
        if (poke) begin
            repeat (8) @(posedge clk);
            #2 start = 1'b1; op = ~o;
            @(posedge clk);
            #1 start = 1'b0; op = o;
        end
        if (abort_at > 0) begin
            while (cyc < start_edge + abort_at - 1) begin @(posedge clk); #1; end
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            if (abort_at <= lat - 1) pending = 1'b0;
        end
        if (rst_at > 0) begin
            while (cyc < start_edge + rst_at) begin @(posedge clk); #1; end
            #1 rst_n = 1'b0;
            pending  = 1'b0;
            held_hi  = '0;
            held_lo  = '0;
            held_ovf = 1'b0;
            #1;
            check("rst_mid busy", 32'(busy), 32'd0);
            check("rst_mid p_hi", 32'(p_hi), 32'd0);
            check("rst_mid p_lo", 32'(p_lo), 32'd0);
            repeat (2) @(posedge clk);
            #2 rst_n = 1'b1;
        end
        g = 0;
        while (pending && g < lat + 20) begin @(posedge clk); #1; g++; end
        if (pending) begin
            total++;
            bad++;
            $display("FAIL timeout: no completion within %0d cycles", lat + 20);
            pending = 1'b0;
        end
        lat_obs = (done_edge >= 0) ? done_edge - start_edge : -1;
    endtask

    initial begin
        int lat_obs;
        logic o;
        logic [W-1:0] aa, bh, bl;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 1'b0;
        a = '0; b_hi = '0; b_lo = '0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset ovf",  32'(ovf),  32'd0);
        check("reset p_hi", 32'(p_hi), 32'd0);
        check("reset p_lo", 32'(p_lo), 32'd0);
        #11 rst_n = 1'b1;

        // MUL 5 * -3 = -15
        run(1'b0, 8'h0A, 8'h00, 8'h07, 0, 0, 1'b0, lat_obs);
        check("mul5x-3 lat",  32'(lat_obs), 32'd100);
        check("mul5x-3 p_hi", 32'(p_hi), 32'h01);
        check("mul5x-3 p_lo", 32'(p_lo), 32'h1F);
        check("mul5x-3 ovf",  32'(ovf), 32'd0);

        // DIV 100 / 7 = 14 r 2
        run(1'b1, 8'h0E, 8'h00, 8'hC8, 0, 0, 1'b0, lat_obs);
        check("div100/7 lat",  32'(lat_obs), 32'd100);
        check("div100/7 p_lo", 32'(p_lo), 32'h1C);
        check("div100/7 p_hi", 32'(p_hi), 32'h04);

        // DIV -(100) / -7: quotient +14, remainder -2
        run(1'b1, 8'h0F, 8'h01, 8'hC8, 0, 0, 1'b0, lat_obs);
        check("divneg p_lo", 32'(p_lo), 32'h1C);
        check("divneg p_hi", 32'(p_hi), 32'h05);

        // Overflow: b_hi mag == divisor, then zero divisor
        run(1'b1, 8'h0E, 8'h0E, 8'h22, 0, 0, 1'b0, lat_obs);
        check("ovf eq lat", 32'(lat_obs), 32'd2);
        check("ovf eq ovf", 32'(ovf), 32'd1);
        check("ovf eq p_hi", 32'(p_hi), 32'd0);
        run(1'b1, 8'h00, 8'h00, 8'h10, 0, 0, 1'b0, lat_obs);
        check("ovf zero lat", 32'(lat_obs), 32'd2);
        check("ovf zero ovf", 32'(ovf), 32'd1);

        // MUL 64 * 3 = 192: low word bit 6 set
        run(1'b0, 8'h80, 8'h00, 8'h06, 0, 0, 1'b0, lat_obs);
`ifdef SERIAL_MUL_DIV_ROUND_EN
        check("mul64x3 p_hi", 32'(p_hi), 32'h04);
`else
        check("mul64x3 p_hi", 32'(p_hi), 32'h02);
`endif
        check("mul64x3 p_lo", 32'(p_lo), 32'h80);

        // -0 * 5 must be +0
        run(1'b0, 8'h01, 8'h00, 8'h0A, 0, 0, 1'b0, lat_obs);
        check("mulzero p_hi", 32'(p_hi), 32'h00);
        check("mulzero p_lo", 32'(p_lo), 32'h00);

        // Abort at edge 50, then a fresh op completes
        run(1'b0, 8'h1E, 8'h00, 8'h14, 50, 0, 1'b0, lat_obs);
        check("abort nodone", 32'(lat_obs), 32'hFFFF_FFFF);
        run(1'b0, 8'h1E, 8'h00, 8'h14, 0, 0, 1'b0, lat_obs);
        check("after abort lat", 32'(lat_obs), 32'd100);

        // Reset at edge 30, then the next start completes
        run(1'b1, 8'h0E, 8'h00, 8'hC8, 0, 30, 1'b0, lat_obs);
        run(1'b0, 8'h0A, 8'h00, 8'h07, 0, 0, 1'b0, lat_obs);
        check("after rst lat",  32'(lat_obs), 32'd100);
        check("after rst p_lo", 32'(p_lo), 32'h1F);

        // Start while busy ignored; abort in DONE ignored
        run(1'b0, 8'h16, 8'h00, 8'h13, 0, 0, 1'b1, lat_obs);
        check("poke lat", 32'(lat_obs), 32'd100);
        run(1'b1, 8'h06, 8'h08, 8'h00, 2, 0, 1'b0, lat_obs);
        check("abort in done lat", 32'(lat_obs), 32'd2);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        check("start+abort busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            o  = 1'($urandom % 2);
            aa = 8'($urandom);
            bl = 8'($urandom);
            bh = 8'($urandom);
            if (o && aa[7:1] != 0 && ($urandom % 4) != 0)
                bh = {7'($urandom_range(0, int'(aa[7:1]) - 1)), 1'($urandom % 2)};
            if (($urandom % 16) == 0) aa[7:1] = 7'd0;
            run(o, aa, bh, bl, 0, 0, 1'b0, lat_obs);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
